interrupt_sequencer: RTL
========================

INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 Parameter: DRAIN_CYCLES, 3, cycles with fetch stalled before the first push.
REQ-002 Parameter: VEC_ADDR, 32'h0000_0002, word address of the high half of the ISR vector; low half is at VEC_ADDR+1.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 interrupt_signal  in  1  external request; only a rising edge counts.
REQ-006 rti  in  1  one-cycle pulse: an RTI has issued.
REQ-007 pipe_busy  in  1  memory stage is occupied; freezes the drain counter.
REQ-008 pc  in  32  resume PC, which is stable while fetch is stalled.
REQ-009 flags  in  3  current flag register {C,N,Z}.
REQ-010 mem_rdata  in  16  data memory read data, valid the cycle after the read.
REQ-011 stall_fetch  out  1  hold PC and the fetch/decode register.
REQ-012 flush_decode  out  1  bubble the decode output for one cycle.
REQ-013 mem_push / mem_pop  out  1 each  stack write/read; SP is adjusted externally.
REQ-014 mem_wdata  out  16  push data.
REQ-015 mem_read_vec  out  1  read at mem_addr (not SP).
REQ-016 mem_addr  out  32  vector address.
REQ-017 pc_load  out  1  load pc_load_value into PC.
REQ-018 pc_load_value  out  32  new PC.
REQ-019 flags_restore  out  1  load flags_value into the flag register.
REQ-020 flags_value  out  3  restored flags.
REQ-021 int_active  out  1  ISR in progress; nesting is blocked.

Function
REQ-022 A rising edge of interrupt_signal (compared with its registered previous value) shall set `pending`; a level held high shall not retrigger.
REQ-023 The FSM states shall be IDLE, DRAIN, PUSH_HI, PUSH_LO, PUSH_FLAGS, VEC_HI, VEC_LO, JUMP, POP_FLAGS, POP_LO, POP_HI, RESUME.
REQ-024 In IDLE, a rti pulse shall go to POP_FLAGS.
REQ-025 In IDLE, when rti is low, pending (or a same-cycle rising edge) is set and int_active=0, the FSM shall go to DRAIN, clear pending and capture pc into pc_saved.
REQ-026 rti shall win over a simultaneous interrupt; the interrupt stays pending.
REQ-027 DRAIN shall count DRAIN_CYCLES cycles in which pipe_busy=0; the counter holds while pipe_busy=1.
REQ-028 On leaving DRAIN, flags shall be captured into flags_saved; the next state is PUSH_HI.
REQ-029 The push states shall each last one cycle with mem_push=1: PUSH_HI writes pc_saved[31:16], PUSH_LO writes pc_saved[15:0], PUSH_FLAGS writes {13'b0, flags_saved}.
REQ-030 VEC_HI shall drive mem_read_vec=1 with mem_addr=VEC_ADDR.
REQ-031 VEC_LO shall drive mem_read_vec=1 with mem_addr=VEC_ADDR+1 and latch mem_rdata into vec_hi.
REQ-032 JUMP shall drive pc_load=1, pc_load_value={vec_hi, mem_rdata}, flush_decode=1 and set int_active; the next state is IDLE.
REQ-033 POP_FLAGS shall drive mem_pop=1.
REQ-034 POP_LO shall drive mem_pop=1, flags_restore=1 and flags_value=mem_rdata[2:0].
REQ-035 POP_HI shall drive mem_pop=1 and latch mem_rdata into pc_lo.
REQ-036 RESUME shall drive pc_load=1, pc_load_value={mem_rdata, pc_lo}, flush_decode=1 and clear int_active; the next state is IDLE.
REQ-037 stall_fetch shall be 1 in every state except IDLE.
REQ-038 All other outputs shall be 0 wherever not stated above.
REQ-039 Interrupt entry latency shall be: edge at cycle t, DRAIN from t+1, pc_load at t+DRAIN_CYCLES+6 when pipe_busy=0.
REQ-040 An edge arriving while not in IDLE, or while int_active=1, shall be held in pending and serviced on the first eligible IDLE cycle.
REQ-041 An rti received outside IDLE shall be ignored.
REQ-042 All state, counter and data outputs shall be registered (Moore), except pc_load_value and flags_value, which shall pass mem_rdata combinationally in JUMP, POP_LO and RESUME.

Reset
REQ-043 Reset shall force IDLE, clear pending, the drain count, int_active, pc_saved, flags_saved, vec_hi, pc_lo and the previous-edge register, and drive all outputs to 0.
REQ-044 Reset shall take effect mid-sequence with no further push or pop.

Structure
REQ-045 The state enum, DRAIN_CYCLES default and VEC_ADDR default shall live in a shared package, int_seq_pkg.
REQ-046 The edge detector plus pending latch shall be one sub-module, irq_edge_latch (inputs: clk, reset, level, clear; output: pending).

Verification
REQ-047 Edge at t with pipe_busy=0, pc=32'h0000_1234, flags=3'b101, vector words 16'h0000, 16'h0100 -> pushes 0000, 1234, 0005; pc_load at t+9 with 32'h0000_0100; int_active=1.
REQ-048 pipe_busy=1 for 2 cycles during DRAIN -> first mem_push delayed exactly 2 cycles.
REQ-049 rti in IDLE, pops return 0005, 1234, 0000 -> flags_value=3'b101 in POP_LO; pc_load 32'h0000_1234 in RESUME; int_active=0.
REQ-050 Edge during the ISR (int_active=1), then rti -> full RTI sequence first, then entry starts in the following cycle; interrupt_signal held high for 20 cycles gives exactly one entry.
REQ-051 rti and edge in the same IDLE cycle -> POP_FLAGS next; entry follows RESUME.
REQ-052 reset asserted in PUSH_LO -> next cycle IDLE, all outputs 0, a later rti alone gives no entry.

Source files
------------

// File: rtl/int_seq_pkg.sv
// ============================================================================
// Module      : int_seq_pkg
// Description : Shared state encoding and default parameters for the
//               interrupt sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package int_seq_pkg;

    localparam int unsigned DRAIN_CYCLES_DEF = 3;
    localparam logic [31:0] VEC_ADDR_DEF     = 32'h0000_0002;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        DRAIN      = 4'd1,
        PUSH_HI    = 4'd2,
        PUSH_LO    = 4'd3,
        PUSH_FLAGS = 4'd4,
        VEC_HI     = 4'd5,
        VEC_LO     = 4'd6,
        JUMP       = 4'd7,
        POP_FLAGS  = 4'd8,
        POP_LO     = 4'd9,
        POP_HI     = 4'd10,
        RESUME     = 4'd11
    } state_t;

endpackage

`default_nettype wire

// File: rtl/interrupt_sequencer_if.sv
// ============================================================================
// Module      : interrupt_sequencer_if
// Description : Core-side bundle between the pipeline/memory and the
//               interrupt sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface interrupt_sequencer_if;

    logic        interrupt_signal;
    logic        rti;
    logic        pipe_busy;
    logic [31:0] pc;
    logic [2:0]  flags;
    logic [15:0] mem_rdata;

    logic        stall_fetch;
    logic        flush_decode;
    logic        mem_push;
    logic        mem_pop;
    logic [15:0] mem_wdata;
    logic        mem_read_vec;
    logic [31:0] mem_addr;
    logic        pc_load;
    logic [31:0] pc_load_value;
    logic        flags_restore;
    logic [2:0]  flags_value;
    logic        int_active;

    modport slave (
        input  interrupt_signal, rti, pipe_busy, pc, flags, mem_rdata,
        output stall_fetch, flush_decode, mem_push, mem_pop, mem_wdata,
               mem_read_vec, mem_addr, pc_load, pc_load_value,
               flags_restore, flags_value, int_active
    );

    modport master (
        output interrupt_signal, rti, pipe_busy, pc, flags, mem_rdata,
        input  stall_fetch, flush_decode, mem_push, mem_pop, mem_wdata,
               mem_read_vec, mem_addr, pc_load, pc_load_value,
               flags_restore, flags_value, int_active
    );

endinterface

`default_nettype wire

// File: rtl/irq_edge_latch.sv
// ============================================================================
// Module      : irq_edge_latch
// Description : Rising-edge detector with a sticky pending flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_edge_latch (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic level,
    input  wire logic clear,
    output logic      pending
);

    logic r_level_d;
    logic r_pending;
    logic w_rise;

    assign w_rise = level & ~r_level_d;

    // A clear consumes both the stored request and any edge in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_level_d <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_level_d <= level;
            r_pending <= clear ? 1'b0 : (r_pending | w_rise);
        end
    end

    assign pending = r_pending | w_rise;

endmodule

`default_nettype wire

// File: rtl/interrupt_sequencer.sv
// ============================================================================
// Module      : interrupt_sequencer
// Description : Interrupt entry (drain, push PC/flags, fetch vector, jump)
//               and RTI exit (pop flags/PC, resume) sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module interrupt_sequencer
    import int_seq_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter logic [31:0] VEC_ADDR     = VEC_ADDR_DEF
) (
    input  wire logic             clk,
    input  wire logic             reset,
    interrupt_sequencer_if.slave  bus
);

    localparam int unsigned   CW           = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CW-1:0] c_drain_last = CW'(DRAIN_CYCLES - 1);

    state_t        r_state;
    state_t        w_state_next;
    logic          w_take_irq;
    logic          w_pending;
    logic [CW-1:0] r_drain_cnt;
    logic [31:0]   r_pc_saved;
    logic [2:0]    r_flags_saved;
    logic [15:0]   r_vec_hi;
    logic [15:0]   r_pc_lo;
    logic          r_int_active;

    irq_edge_latch u_edge (
        .clk     (clk),
        .reset   (reset),
        .level   (bus.interrupt_signal),
        .clear   (w_take_irq),
        .pending (w_pending)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // rti has priority in IDLE; an interrupt seen at the same time stays pending
    always_comb begin
        w_state_next = r_state;
        w_take_irq   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.rti) begin
                    w_state_next = POP_FLAGS;
                end else if (w_pending && !r_int_active) begin
                    w_state_next = DRAIN;
                    w_take_irq   = 1'b1;
                end
            end
            DRAIN:      if (!bus.pipe_busy && r_drain_cnt == c_drain_last) w_state_next = PUSH_HI;
            PUSH_HI:    w_state_next = PUSH_LO;
            PUSH_LO:    w_state_next = PUSH_FLAGS;
            PUSH_FLAGS: w_state_next = VEC_HI;
            VEC_HI:     w_state_next = VEC_LO;
            VEC_LO:     w_state_next = JUMP;
            JUMP:       w_state_next = IDLE;
            POP_FLAGS:  w_state_next = POP_LO;
            POP_LO:     w_state_next = POP_HI;
            POP_HI:     w_state_next = RESUME;
            RESUME:     w_state_next = IDLE;
            default:    w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_drain_cnt   <= '0;
            r_pc_saved    <= '0;
            r_flags_saved <= '0;
            r_vec_hi      <= '0;
            r_pc_lo       <= '0;
            r_int_active  <= 1'b0;
        end else begin
            if (w_take_irq) r_pc_saved <= bus.pc;
            if (r_state == DRAIN) begin
                if (!bus.pipe_busy) begin
                    if (r_drain_cnt == c_drain_last) begin
                        r_drain_cnt   <= '0;
                        r_flags_saved <= bus.flags;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + CW'(1);
                    end
                end
            end else begin
                r_drain_cnt <= '0;
            end
            if (r_state == VEC_LO) r_vec_hi <= bus.mem_rdata;
            if (r_state == POP_HI) r_pc_lo  <= bus.mem_rdata;
            if (r_state == JUMP)        r_int_active <= 1'b1;
            else if (r_state == RESUME) r_int_active <= 1'b0;
        end
    end

    // Memory read data arrives one cycle after the request, so JUMP/POP_LO/RESUME forward it directly
    always_comb begin
        bus.stall_fetch   = (r_state != IDLE);
        bus.flush_decode  = 1'b0;
        bus.mem_push      = 1'b0;
        bus.mem_pop       = 1'b0;
        bus.mem_wdata     = '0;
        bus.mem_read_vec  = 1'b0;
        bus.mem_addr      = '0;
        bus.pc_load       = 1'b0;
        bus.pc_load_value = '0;
        bus.flags_restore = 1'b0;
        bus.flags_value   = '0;
        case (r_state)
            PUSH_HI: begin
                bus.mem_push  = 1'b1;
                bus.mem_wdata = r_pc_saved[31:16];
            end
            PUSH_LO: begin
                bus.mem_push  = 1'b1;
                bus.mem_wdata = r_pc_saved[15:0];
            end
            PUSH_FLAGS: begin
                bus.mem_push  = 1'b1;
                bus.mem_wdata = {13'b0, r_flags_saved};
            end
            VEC_HI: begin
                bus.mem_read_vec = 1'b1;
                bus.mem_addr     = VEC_ADDR;
            end
            VEC_LO: begin
                bus.mem_read_vec = 1'b1;
                bus.mem_addr     = VEC_ADDR + 32'd1;
            end
            JUMP: begin
                bus.pc_load       = 1'b1;
                bus.pc_load_value = {r_vec_hi, bus.mem_rdata};
                bus.flush_decode  = 1'b1;
            end
            POP_FLAGS: bus.mem_pop = 1'b1;
            POP_LO: begin
                bus.mem_pop       = 1'b1;
                bus.flags_restore = 1'b1;
                bus.flags_value   = bus.mem_rdata[2:0];
            end
            POP_HI: bus.mem_pop = 1'b1;
            RESUME: begin
                bus.pc_load       = 1'b1;
                bus.pc_load_value = {bus.mem_rdata, r_pc_lo};
                bus.flush_decode  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.int_active = r_int_active;

endmodule

`default_nettype wire
